// File: rtl/chip8_framebuffer.sv
// 64x32 Chip-8 framebuffer: display read port plus XOR/clear/read command engine.
// Define FB_WRAP_EN to wrap sprite pixels past column 63 back to column 0.
module chip8_framebuffer #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic [10:0] fb_request_addr,
    output logic        fb_pixel_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [5:0]  cmd_x,
    input  logic [4:0]  cmd_y,
    input  logic [7:0]  cmd_byte,
    output logic        done,
    output logic        collision,
    output logic        rd_pixel
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_XOR,
        S_CLEAR,
        S_READ,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [5:0]  x_q;
    logic [4:0]  y_q;
    logic [7:0]  byte_q;
    logic        auto_q, auto_d;
    logic        acc_q, acc_d;
    logic        coll_q, coll_d;
    logic        rdpix_q, rdpix_d;
    logic        ready_q;
    logic        fb_q;
    logic        accept;

    logic        mem_q [2048];
    logic        we;
    logic [10:0] waddr;
    logic        wdata;

    logic [6:0]  px;
    logic [10:0] xaddr;
    logic        bit_sel;
    logic        clip;
    logic        cur;
    logic        hit;

    assign px      = {1'b0, x_q} + {4'b0, cnt_q[2:0]};
    assign xaddr   = {y_q, px[5:0]};
    assign bit_sel = byte_q[3'd7 - cnt_q[2:0]];
`ifdef FB_WRAP_EN
    assign clip    = 1'b0;
`else
    assign clip    = px[6];
`endif
    assign cur     = mem_q[xaddr];
    assign hit     = cur & bit_sel & ~clip;
    assign accept  = cmd_valid & ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        auto_d  = auto_q;
        acc_d   = acc_q;
        coll_d  = coll_q;
        rdpix_d = rdpix_q;
        we      = 1'b0;
        waddr   = xaddr;
        wdata   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    acc_d = 1'b0;
                    unique case (cmd_op)
                        2'b00:   state_d = S_XOR;
                        2'b01:   state_d = S_CLEAR;
                        2'b10:   state_d = S_READ;
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_XOR: begin
                we    = ~clip;
                waddr = xaddr;
                wdata = cur ^ bit_sel;
                acc_d = acc_q | hit;
                cnt_d = cnt_q + 11'd1;
                if (cnt_q[2:0] == 3'd7) begin
                    coll_d  = acc_q | hit;
                    state_d = S_DONE;
                end
            end
            S_CLEAR: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = 1'b0;
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == 11'd2047) begin
                    // The post-reset sweep finishes silently.
                    auto_d  = 1'b0;
                    state_d = auto_q ? S_IDLE : S_DONE;
                end
            end
            S_READ: begin
                rdpix_d = mem_q[{y_q, x_q}];
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
            auto_q  <= CLEAR_ON_RESET;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            byte_q  <= '0;
            acc_q   <= 1'b0;
            coll_q  <= 1'b0;
            rdpix_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            auto_q  <= auto_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            coll_q  <= coll_d;
            rdpix_q <= rdpix_d;
            ready_q <= (state_d == S_IDLE);
            if (accept) begin
                x_q    <= cmd_x;
                y_q    <= cmd_y;
                byte_q <= cmd_byte;
            end
        end
    end

    // Display read samples the array before this cycle's write lands.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            fb_q <= 1'b0;
        end else begin
            fb_q <= mem_q[fb_request_addr];
        end
    end

    always_ff @(posedge clk50) begin
        if (we && reset_n) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign fb_pixel_data = fb_q;
    assign cmd_ready     = ready_q;
    assign done          = (state_q == S_DONE);
    assign collision     = coll_q;
    assign rd_pixel      = rdpix_q;

endmodule

// File: tb/tb_chip8_framebuffer.sv
// Randomized self-checking bench for chip8_framebuffer against a pixel-array model.
module tb_chip8_framebuffer;

    logic        clk50 = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] fb_request_addr = '0;
    logic        fb_pixel_data;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [5:0]  cmd_x = '0;
    logic [4:0]  cmd_y = '0;
    logic [7:0]  cmd_byte = '0;
    logic        done;
    logic        collision;
    logic        rd_pixel;

    int checks = 0;
    int passed = 0;
    bit model [2048];

    chip8_framebuffer dut (
        .clk50          (clk50),
        .reset_n        (reset_n),
        .fb_request_addr(fb_request_addr),
        .fb_pixel_data  (fb_pixel_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_x          (cmd_x),
        .cmd_y          (cmd_y),
        .cmd_byte       (cmd_byte),
        .done           (done),
        .collision      (collision),
        .rd_pixel       (rd_pixel)
    );

    always #10 clk50 = ~clk50;

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic bit model_xor(input int x, input int y, input logic [7:0] b);
        bit c = 1'b0;
        int px;
        for (int i = 0; i < 8; i++) begin
            px = x + i;
`ifdef FB_WRAP_EN
            px = px % 64;
`else
            if (px >= 64) continue;
`endif
            if (b[7-i]) begin
                if (model[y*64+px]) c = 1'b1;
                model[y*64+px] = ~model[y*64+px];
            end
        end
        return c;
    endfunction

    task automatic model_clear();
        for (int a = 0; a < 2048; a++) model[a] = 1'b0;
    endtask

    // Called at a negedge; returns cycles from accept edge to done (or -1).
    task automatic issue(input logic [1:0] op, input int x, input int y,
                         input logic [7:0] b, output int lat);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 5000) begin
            @(negedge clk50);
            n++;
        end
        lat = -1;
        if (n >= 5000) begin
            checks++;
            $display("FAIL ready_timeout: cmd_ready never rose");
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x[5:0];
        cmd_y     = y[4:0];
        cmd_byte  = b;
        @(negedge clk50);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_x     = 6'($urandom);
        cmd_y     = 5'($urandom);
        cmd_byte  = 8'($urandom);
        n = 1;
        while (done !== 1'b1 && n < 5000) begin
            @(negedge clk50);
            n++;
        end
        if (done === 1'b1) lat = n;
    endtask

    task automatic disp(input int a, output logic v);
        fb_request_addr = a[10:0];
        @(negedge clk50);
        v = fb_pixel_data;
    endtask

    task automatic wait_auto_clear(input string tag);
        int  n = 0;
        bit  saw_done = 1'b0;
        while (cmd_ready !== 1'b1 && n < 5000) begin
            @(negedge clk50);
            n++;
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (n !== 2048)
            $display("FAIL %s_ready_delay: got %0d cycles, expected 2048", tag, n);
        else passed++;
        checks++;
        if (saw_done !== 1'b0)
            $display("FAIL %s_no_done: done pulsed during auto-clear", tag);
        else passed++;
        model_clear();
    endtask

    task automatic test_reset();
        logic v;
        int   addrs [3] = '{0, 1000, 2047};
        repeat (3) @(negedge clk50);
        checks++;
        if ({cmd_ready, done, collision, rd_pixel, fb_pixel_data} !== 5'b0)
            $display("FAIL reset_outputs: got %b, expected 00000",
                     {cmd_ready, done, collision, rd_pixel, fb_pixel_data});
        else passed++;
        reset_n = 1'b1;
        wait_auto_clear("reset");
        foreach (addrs[k]) begin
            disp(addrs[k], v);
            checks++;
            if (v !== 1'b0)
                $display("FAIL reset_pixel_%0d: got %b, expected 0", addrs[k], v);
            else passed++;
        end
    endtask

    task automatic check_row(input string tag, input int base, input int cnt);
        logic v;
        for (int a = base; a < base + cnt; a++) begin
            disp(a, v);
            checks++;
            if (v !== model[a])
                $display("FAIL %s_pix_%0d: got %b, expected %b", tag, a, v, model[a]);
            else passed++;
        end
    endtask

    task automatic test_xor_basic();
        int lat;
        bit exp;
        issue(2'b00, 10, 5, 8'hA5, lat);
        exp = model_xor(10, 5, 8'hA5);
        checks++;
        if (lat !== 9) $display("FAIL xor_latency: got %0d, expected 9", lat);
        else passed++;
        checks++;
        if (collision !== exp)
            $display("FAIL xor_collision: got %b, expected %b", collision, exp);
        else passed++;
        @(negedge clk50);
        checks++;
        if ({done, cmd_ready} !== 2'b01)
            $display("FAIL done_pulse: done/ready got %b, expected 01", {done, cmd_ready});
        else passed++;
        check_row("xor", 330, 8);
    endtask

    task automatic test_xor_repeat();
        int lat;
        bit exp;
        issue(2'b00, 10, 5, 8'hA5, lat);
        exp = model_xor(10, 5, 8'hA5);
        checks++;
        if (collision !== exp || exp !== 1'b1)
            $display("FAIL repeat_collision: got %b, expected %b", collision, exp);
        else passed++;
        check_row("repeat", 330, 8);
    endtask

    task automatic test_clip();
        int lat;
        bit exp;
        issue(2'b00, 60, 0, 8'hFF, lat);
        exp = model_xor(60, 0, 8'hFF);
        checks++;
        if (lat !== 9) $display("FAIL clip_latency: got %0d, expected 9", lat);
        else passed++;
        checks++;
        if (collision !== exp)
            $display("FAIL clip_collision: got %b, expected %b", collision, exp);
        else passed++;
        check_row("clip_hi", 60, 4);
        check_row("clip_lo", 0, 4);
    endtask

    task automatic test_read_clear();
        int   lat;
        int   bad = 0;
        bit   exp;
        logic v;
        issue(2'b10, 60, 0, 8'h00, lat);
        checks++;
        if (lat !== 2) $display("FAIL read_latency: got %0d, expected 2", lat);
        else passed++;
        checks++;
        if (rd_pixel !== model[60])
            $display("FAIL read_pixel: got %b, expected %b", rd_pixel, model[60]);
        else passed++;
        issue(2'b00, 60, 0, 8'h80, lat);
        exp = model_xor(60, 0, 8'h80);
        checks++;
        if (collision !== exp)
            $display("FAIL pre_clear_collision: got %b, expected %b", collision, exp);
        else passed++;
        issue(2'b01, 0, 0, 8'h00, lat);
        model_clear();
        checks++;
        if (lat !== 2049) $display("FAIL clear_latency: got %0d, expected 2049", lat);
        else passed++;
        checks++;
        if (collision !== exp || rd_pixel !== 1'b1)
            $display("FAIL clear_holds: coll/rd got %b%b, expected %b1", collision, rd_pixel, exp);
        else passed++;
        for (int a = 0; a < 2048; a++) begin
            disp(a, v);
            if (v !== 1'b0) begin
                if (bad < 4) $display("FAIL clear_pix_%0d: got %b, expected 0", a, v);
                bad++;
            end
        end
        checks++;
        if (bad !== 0) $display("FAIL clear_all: got %0d lit pixels, expected 0", bad);
        else passed++;
    endtask

    task automatic test_random();
        int   lat, x, y;
        bit   exp;
        logic [7:0] b;
        logic v;
        for (int t = 0; t < 30; t++) begin
            x = $urandom_range(63);
            y = $urandom_range(31);
            b = 8'($urandom);
            if ($urandom_range(9) < 7) begin
                issue(2'b00, x, y, b, lat);
                exp = model_xor(x, y, b);
                checks++;
                if (lat !== 9 || collision !== exp)
                    $display("FAIL rand_xor_%0d: lat %0d coll %b, expected 9 %b", t, lat, collision, exp);
                else passed++;
            end else begin
                issue(2'b10, x, y, b, lat);
                checks++;
                if (lat !== 2 || rd_pixel !== model[y*64+x])
                    $display("FAIL rand_read_%0d: lat %0d rd %b, expected 2 %b", t, lat, rd_pixel, model[y*64+x]);
                else passed++;
            end
        end
        for (int t = 0; t < 32; t++) begin
            x = $urandom_range(2047);
            disp(x, v);
            checks++;
            if (v !== model[x])
                $display("FAIL rand_disp_%0d: got %b, expected %b", x, v, model[x]);
            else passed++;
        end
    endtask

    task automatic test_reserved();
        int   lat, a;
        logic c0, r0, v;
        c0 = collision;
        r0 = rd_pixel;
        issue(2'b11, 7, 7, 8'hFF, lat);
        checks++;
        if (lat !== 1) $display("FAIL reserved_latency: got %0d, expected 1", lat);
        else passed++;
        checks++;
        if ({collision, rd_pixel} !== {c0, r0})
            $display("FAIL reserved_holds: got %b%b, expected %b%b", collision, rd_pixel, c0, r0);
        else passed++;
        check_row("reserved", 7*64+7, 8);
        a = $urandom_range(2047);
        disp(a, v);
        checks++;
        if (v !== model[a]) $display("FAIL reserved_disp: got %b, expected %b", v, model[a]);
        else passed++;
    endtask

    task automatic test_back_to_back_rbw();
        int   a = 7*64 + 20;
        int   n;
        bit   old, exp;
        old = model[a];
        fb_request_addr = a[10:0];
        n = 0;
        while (cmd_ready !== 1'b1 && n < 5000) begin
            @(negedge clk50);
            n++;
        end
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_x     = 6'd20;
        cmd_y     = 5'd7;
        cmd_byte  = 8'h80;
        @(negedge clk50);
        cmd_valid = 1'b0;
        @(negedge clk50);
        checks++;
        if (fb_pixel_data !== old)
            $display("FAIL rbw_old: got %b, expected %b", fb_pixel_data, old);
        else passed++;
        @(negedge clk50);
        checks++;
        if (fb_pixel_data !== ~old)
            $display("FAIL rbw_new: got %b, expected %b", fb_pixel_data, ~old);
        else passed++;
        exp = model_xor(20, 7, 8'h80);
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clk50);
            n++;
        end
        checks++;
        if (done !== 1'b1 || collision !== exp)
            $display("FAIL rbw_done: done %b coll %b, expected 1 %b", done, collision, exp);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit exp;
        issue(2'b01, 0, 0, 8'h00, lat);
        model_clear();
        issue(2'b00, 0, 3, 8'hFF, lat);
        exp = model_xor(0, 3, 8'hFF);
        issue(2'b10, 1, 3, 8'h00, lat);
        issue(2'b00, 0, 3, 8'h80, lat);
        exp = model_xor(0, 3, 8'h80);
        checks++;
        if ({collision, rd_pixel} !== {exp, 1'b1})
            $display("FAIL mid_setup: coll/rd got %b%b, expected %b1", collision, rd_pixel, exp);
        else passed++;
        fb_request_addr = 11'(3*64 + 1);
        @(negedge clk50);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_x     = 6'd8;
        cmd_y     = 5'd3;
        cmd_byte  = 8'hFF;
        @(negedge clk50);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk50);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, done, collision, rd_pixel, fb_pixel_data} !== 5'b0)
            $display("FAIL mid_reset_outputs: got %b, expected 00000",
                     {cmd_ready, done, collision, rd_pixel, fb_pixel_data});
        else passed++;
        repeat (3) @(negedge clk50);
        reset_n = 1'b1;
        wait_auto_clear("mid");
        check_row("mid", 3*64, 12);
    endtask

    initial begin
        test_reset();
        test_xor_basic();
        test_xor_repeat();
        test_clip();
        test_read_clear();
        test_random();
        test_reserved();
        test_back_to_back_rbw();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
